melody_player: RTL and testbench
================================

# melody_player

Score sequencer that steps through a fixed two-channel melody at a programmable beat rate. It translates each beat's tone codes into the 22-bit half-period divisors consumed by the square-wave note generator (`note_div_left` / `note_div_right`). It sits directly upstream of the note generator and is controlled by the top-level button or FSM logic.

## Interface
Parameters:
- `CLK_HZ`, default 100_000_000: system clock frequency. Used only for divisor computation.
- `BEAT_CYCLES`, default 12_500_000: clk cycles per beat (8 beats/s at default clock).
- `SONG_LEN`, default 64: number of score entries, at most 64.
- `GAP_CYCLES`, default 1_000_000: articulation gap length. Used only with `MELODY_ARTIC_EN`.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `start`, in, 1: single-cycle pulse. Start from beat 0, or restart if already playing.
- `stop`, in, 1: single-cycle pulse. Return to idle.
- `pause_toggle`, in, 1: single-cycle pulse. PLAY↔PAUSE.
- `loop_en`, in, 1: level. Wrap to beat 0 at end of song instead of stopping.
- `note_div_left`, out, 22: left divisor. 22'd1 = silence.
- `note_div_right`, out, 22: right divisor. 22'd1 = silence.
- `beat_idx`, out, 6: current score entry.
- `busy`, out, 1: high in PLAY or PAUSE.
- `done`, out, 1: one-cycle pulse when the last beat completes.

## Operation
- FSM states: IDLE, PLAY, PAUSE. Reset state is IDLE.
- Input priority when pulses coincide: `stop` > `start` > `pause_toggle`.
- **IDLE**
  - `start` → PLAY, with `beat_idx`=0 and the tick counter cleared.
  - `pause_toggle` is ignored.
- **PLAY**
  - The tick counter counts 0..BEAT_CYCLES-1.
  - At terminal count, `beat_idx` advances.
  - At terminal count on entry SONG_LEN-1:
    - `done` pulses.
    - If `loop_en`=1: `beat_idx`→0 and stay in PLAY.
    - Otherwise: IDLE, `beat_idx`→0.
  - `start` restarts: `beat_idx`=0, counter=0.
  - `pause_toggle` → PAUSE.
- **PAUSE**
  - Tick counter and `beat_idx` are frozen.
  - `pause_toggle` → PLAY and resumes the count where it stopped.
  - `start` → PLAY from beat 0.
- `stop` in any state → IDLE, `beat_idx`=0, counter=0. No `done` pulse.
- Tone codes are 6 bits:
  - Code 0 = rest, which outputs divisor 22'd1.
  - Codes 1..36 = semitone (code−1) above C3.
  - Codes 37..63 are treated as rest.
- Divisor = (CLK_HZ·50)/freq_centihz − 1, with truncating integer division, computed at elaboration. Examples at defaults:
  - A4 (code 22, 44000 cHz) → 113635.
  - C4 (code 13, 26163 cHz) → 191108.
- Outputs in IDLE and PAUSE are 22'd1 on both channels.
- `done` is also asserted with `loop_en`=1 on each wrap.

## Timing
- Reset values:
  - `note_div_left` = `note_div_right` = 22'd1.
  - `beat_idx`=0, `busy`=0, `done`=0.
  - State IDLE, counter 0.
- All outputs are registered.
- `busy` and `beat_idx` change in the cycle after the triggering pulse or terminal count.
- `note_div_*` lag `beat_idx` by exactly one cycle (registered LUT stage).
- Beat duration is exactly BEAT_CYCLES cycles, measured between successive `beat_idx` changes.
- `done` is high for the single cycle in which `beat_idx` returns to 0.
- Reset mid-song forces all reset values asynchronously. There is no resumption after reset.

## Configuration
- Macro: `MELODY_ARTIC_EN`.
- With `MELODY_ARTIC_EN` defined:
  - During the final GAP_CYCLES cycles of a beat, a channel outputs 22'd1 if the next entry on that channel carries the same nonzero code.
  - This separates repeated notes audibly.
  - The last entry compares against entry 0 only when `loop_en`=1.
- Without the macro: the divisor is held for the full beat. There is no gap logic and no `GAP_CYCLES` comparator.

## Structure
- Package `melody_pkg` holds:
  - The tone code width and the REST code constant.
  - The 36-entry `FREQ_CENTIHZ` table.
  - The `SCORE_L` and `SCORE_R` 64-entry code arrays.
  - The state enum type.
- Score entries 0..3 are fixed for bring-up:
  - L = 22, 22, 0, 13.
  - R = 0, 13, 13, 0.
- Sub-module: `tone_div_lut`. It maps a 6-bit code to a 22-bit divisor, uses CLK_HZ, and is combinational. It is instantiated once per channel.

## Test plan
Bench uses BEAT_CYCLES=16, defaults otherwise, and macro off unless stated.
- Reset released, no stimulus → divs 1/1, `busy`=0, `beat_idx`=0 for 100 cycles.
- `start` pulse → `busy`=1 next cycle. Then:
  - `note_div_left`=113635 and `note_div_right`=1 one cycle after that.
  - `beat_idx`=1 after 16 cycles; divs become 113635/191108.
- `pause_toggle` at cycle 5 of beat 2, held 40 cycles, then `pause_toggle` again → divs 1/1 while paused, and beat 2 ends 11 cycles after resume.
- Run to end with `loop_en`=0 → one `done` pulse after SONG_LEN·16 cycles, then IDLE with `busy`=0. With `loop_en`=1 → `done` pulses each wrap and `beat_idx` returns to 0.
- Same-cycle `stop`+`start` in PLAY → IDLE, divs 1/1. `start` alone mid-song → `beat_idx`=0 next cycle.
- `MELODY_ARTIC_EN`, GAP_CYCLES=4 → left=1 during the last 4 cycles of beat 0 (entry 1 repeats code 22), and right is unaffected.

Source files
------------

// File: rtl/melody_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : melody_pkg
//  Purpose  : Tone-code constants, note frequency table, two-channel score
//             and sequencer state type shared by the melody player.
//  Revision : 1.0  initial release
// ============================================================================
package melody_pkg;

    localparam int c_TONE_W    = 6;
    localparam int c_DIV_W     = 22;
    localparam int c_NUM_TONES = 36;
    localparam int c_SCORE_LEN = 64;

    localparam logic [c_TONE_W-1:0] c_REST        = 6'd0;
    localparam logic [c_DIV_W-1:0]  c_DIV_SILENCE = 22'd1;

    // Equal-tempered C3..B5 in centihertz; entry i is semitone i above C3.
    localparam int unsigned FREQ_CENTIHZ [c_NUM_TONES] = '{
        13081, 13859, 14683, 15556, 16481, 17461, 18500, 19600, 20765, 22000, 23308, 24694,
        26163, 27718, 29366, 31113, 32963, 34923, 36999, 39200, 41530, 44000, 46616, 49388,
        52325, 55437, 58733, 62225, 65926, 69846, 73999, 78399, 83061, 88000, 93233, 98777
    };

    localparam logic [c_TONE_W-1:0] SCORE_L [c_SCORE_LEN] = '{
        6'd22, 6'd22, 6'd0,  6'd13, 6'd17, 6'd17, 6'd20, 6'd20,
        6'd22, 6'd22, 6'd20, 6'd0,  6'd18, 6'd18, 6'd17, 6'd17,
        6'd15, 6'd15, 6'd13, 6'd0,  6'd20, 6'd20, 6'd18, 6'd18,
        6'd17, 6'd17, 6'd15, 6'd0,  6'd20, 6'd20, 6'd18, 6'd18,
        6'd17, 6'd17, 6'd15, 6'd0,  6'd13, 6'd13, 6'd20, 6'd20,
        6'd22, 6'd22, 6'd20, 6'd0,  6'd18, 6'd18, 6'd17, 6'd17,
        6'd15, 6'd15, 6'd13, 6'd0,  6'd25, 6'd24, 6'd22, 6'd20,
        6'd18, 6'd17, 6'd15, 6'd13, 6'd0,  6'd13, 6'd0,  6'd13
    };

    localparam logic [c_TONE_W-1:0] SCORE_R [c_SCORE_LEN] = '{
        6'd0,  6'd13, 6'd13, 6'd0,  6'd1,  6'd0,  6'd8,  6'd0,
        6'd6,  6'd0,  6'd1,  6'd0,  6'd6,  6'd0,  6'd1,  6'd0,
        6'd8,  6'd0,  6'd1,  6'd0,  6'd1,  6'd0,  6'd6,  6'd0,
        6'd1,  6'd0,  6'd8,  6'd0,  6'd1,  6'd0,  6'd6,  6'd0,
        6'd1,  6'd0,  6'd8,  6'd0,  6'd1,  6'd0,  6'd8,  6'd0,
        6'd6,  6'd0,  6'd1,  6'd0,  6'd6,  6'd0,  6'd1,  6'd0,
        6'd8,  6'd0,  6'd1,  6'd0,  6'd6,  6'd0,  6'd8,  6'd0,
        6'd6,  6'd0,  6'd8,  6'd0,  6'd1,  6'd0,  6'd1,  6'd0
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

endpackage : melody_pkg
`default_nettype wire

// File: rtl/tone_div_lut.sv
`default_nettype none
// ============================================================================
//  Module   : tone_div_lut
//  Purpose  : Combinational map from a 6-bit tone code to the half-period
//             divisor of the square-wave note generator; rests map to 1.
//  Revision : 1.0  initial release
// ============================================================================
module tone_div_lut
    import melody_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic [c_TONE_W-1:0] i_code,
    output logic [c_DIV_W-1:0]  o_div
);

    logic [c_DIV_W-1:0] w_table [2**c_TONE_W];

    // Every entry is an elaboration-time constant; only the final mux is logic.
    for (genvar gi = 0; gi < 2**c_TONE_W; gi++) begin : g_table
        if (gi >= 1 && gi <= c_NUM_TONES) begin : g_tone
            localparam logic [c_DIV_W-1:0] c_DIV = c_DIV_W'(
                (64'(CLK_HZ) * 64'd50) / 64'(FREQ_CENTIHZ[gi-1]) - 64'd1);
            assign w_table[gi] = c_DIV;
        end else begin : g_rest
            assign w_table[gi] = c_DIV_SILENCE;
        end
    end

    assign o_div = w_table[i_code];

endmodule : tone_div_lut
`default_nettype wire

// File: rtl/melody_player.sv
`default_nettype none
// ============================================================================
//  Module   : melody_player
//  Purpose  : Two-channel score sequencer producing note divisors per beat.
//             Optional macro MELODY_ARTIC_EN inserts a gap before repeats.
//  Revision : 1.0  initial release
// ============================================================================
module melody_player
    import melody_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int BEAT_CYCLES = 12_500_000,
    parameter int SONG_LEN    = 64,
    parameter int GAP_CYCLES  = 1_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               pause_toggle,
    input  logic               loop_en,
    output logic [c_DIV_W-1:0] note_div_left,
    output logic [c_DIV_W-1:0] note_div_right,
    output logic [5:0]         beat_idx,
    output logic               busy,
    output logic               done
);

    localparam int c_CNT_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(BEAT_CYCLES - 1);
    localparam logic [5:0]         c_BEAT_LAST = 6'(SONG_LEN - 1);

    if (SONG_LEN < 1 || SONG_LEN > c_SCORE_LEN || BEAT_CYCLES < 1 ||
        GAP_CYCLES < 0 || GAP_CYCLES > BEAT_CYCLES) begin : g_param_check
        $error("melody_player: illegal SONG_LEN/BEAT_CYCLES/GAP_CYCLES");
    end

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [5:0]           r_beat;
    logic                 r_busy;
    logic                 r_done;
    logic [c_DIV_W-1:0]   r_div_l;
    logic [c_DIV_W-1:0]   r_div_r;

    state_t               w_state_nx;
    logic [c_CNT_W-1:0]   w_cnt_nx;
    logic [5:0]           w_beat_nx;
    logic                 w_done_nx;
    logic [c_DIV_W-1:0]   w_div_l_nx;
    logic [c_DIV_W-1:0]   w_div_r_nx;
    logic                 w_term;
    logic [c_TONE_W-1:0]  w_code_l;
    logic [c_TONE_W-1:0]  w_code_r;
    logic [c_DIV_W-1:0]   w_lut_l;
    logic [c_DIV_W-1:0]   w_lut_r;
    logic                 w_gap_l;
    logic                 w_gap_r;

    assign w_term   = (r_cnt == c_CNT_LAST);
    assign w_code_l = SCORE_L[r_beat];
    assign w_code_r = SCORE_R[r_beat];

    tone_div_lut #(.CLK_HZ(CLK_HZ)) u_lut_l (
        .i_code (w_code_l),
        .o_div  (w_lut_l)
    );

    tone_div_lut #(.CLK_HZ(CLK_HZ)) u_lut_r (
        .i_code (w_code_r),
        .o_div  (w_lut_r)
    );

`ifdef MELODY_ARTIC_EN
    localparam int unsigned c_GAP_START = BEAT_CYCLES - GAP_CYCLES;

    logic [5:0] w_next_idx;
    logic       w_next_valid;
    logic       w_in_gap;

    // The last entry only has a successor when the song is about to wrap.
    assign w_next_idx   = (r_beat == c_BEAT_LAST) ? 6'd0 : r_beat + 6'd1;
    assign w_next_valid = (r_beat != c_BEAT_LAST) || loop_en;
    assign w_in_gap     = (GAP_CYCLES != 0) && (32'(r_cnt) >= c_GAP_START);
    assign w_gap_l      = w_in_gap && w_next_valid && (w_code_l != c_REST) &&
                          (SCORE_L[w_next_idx] == w_code_l);
    assign w_gap_r      = w_in_gap && w_next_valid && (w_code_r != c_REST) &&
                          (SCORE_R[w_next_idx] == w_code_r);
`else
    assign w_gap_l = 1'b0;
    assign w_gap_r = 1'b0;
`endif

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_beat_nx  = r_beat;
        w_done_nx  = 1'b0;
        if (stop) begin
            w_state_nx = ST_IDLE;
            w_cnt_nx   = '0;
            w_beat_nx  = '0;
        end else if (start) begin
            w_state_nx = ST_PLAY;
            w_cnt_nx   = '0;
            w_beat_nx  = '0;
        end else begin
            unique case (r_state)
                ST_PLAY: begin
                    // A pause on this edge freezes the count where it stands.
                    if (pause_toggle) begin
                        w_state_nx = ST_PAUSE;
                    end else if (w_term) begin
                        w_cnt_nx = '0;
                        if (r_beat == c_BEAT_LAST) begin
                            w_done_nx = 1'b1;
                            w_beat_nx = '0;
                            if (!loop_en) begin
                                w_state_nx = ST_IDLE;
                            end
                        end else begin
                            w_beat_nx = r_beat + 6'd1;
                        end
                    end else begin
                        w_cnt_nx = r_cnt + 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (pause_toggle) begin
                        w_state_nx = ST_PLAY;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_div_l_nx = c_DIV_SILENCE;
        w_div_r_nx = c_DIV_SILENCE;
        if (r_state == ST_PLAY) begin
            w_div_l_nx = w_gap_l ? c_DIV_SILENCE : w_lut_l;
            w_div_r_nx = w_gap_r ? c_DIV_SILENCE : w_lut_r;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_beat  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_div_l <= c_DIV_SILENCE;
            r_div_r <= c_DIV_SILENCE;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_beat  <= w_beat_nx;
            r_busy  <= (w_state_nx != ST_IDLE);
            r_done  <= w_done_nx;
            r_div_l <= w_div_l_nx;
            r_div_r <= w_div_r_nx;
        end
    end

    assign note_div_left  = r_div_l;
    assign note_div_right = r_div_r;
    assign beat_idx       = r_beat;
    assign busy           = r_busy;
    assign done           = r_done;

endmodule : melody_player
`default_nettype wire

// File: tb/tb_melody_player.sv
`default_nettype none
// ============================================================================
//  Module   : tb_melody_player
//  Purpose  : Directed self-checking bench for melody_player (BEAT_CYCLES=16).
//  Revision : 1.0  initial release
// ============================================================================
module tb_melody_player;

    localparam int c_DIV_A4 = 113635;
    localparam int c_DIV_C4 = 191108;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        pause_toggle = 1'b0;
    logic        loop_en = 1'b0;
    logic [21:0] note_div_left;
    logic [21:0] note_div_right;
    logic [5:0]  beat_idx;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    melody_player #(
        .BEAT_CYCLES (16),
        .GAP_CYCLES  (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .stop           (stop),
        .pause_toggle   (pause_toggle),
        .loop_en        (loop_en),
        .note_div_left  (note_div_left),
        .note_div_right (note_div_right),
        .beat_idx       (beat_idx),
        .busy           (busy),
        .done           (done)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // 0=start 1=stop 2=pause_toggle 3=stop+start
    task automatic pulse(input int which);
        start        = (which == 0) || (which == 3);
        stop         = (which == 1) || (which == 3);
        pause_toggle = (which == 2);
        tick(1);
        start        = 1'b0;
        stop         = 1'b0;
        pause_toggle = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!done && n < limit);
    endtask

    int n_cyc;

    initial begin
        tick(3);
        check_val("rst_div_l", note_div_left, 1);
        check_val("rst_busy", busy, 0);
        rst = 1'b0;

        for (int i = 0; i < 100; i++) begin
            tick(1);
            check_val("idle_div_l", note_div_left, 1);
            check_val("idle_div_r", note_div_right, 1);
            check_val("idle_busy", busy, 0);
            check_val("idle_beat", beat_idx, 0);
            check_val("idle_done", done, 0);
        end

        // Start, first beat and first beat boundary
        pulse(0);
        check_val("start_busy", busy, 1);
        check_val("start_beat", beat_idx, 0);
        tick(1);
        check_val("b0_div_l", note_div_left, c_DIV_A4);
        check_val("b0_div_r", note_div_right, 1);
        tick(14);
        check_val("b0_end_beat", beat_idx, 0);
        tick(1);
        check_val("b1_beat", beat_idx, 1);
        tick(1);
        check_val("b1_div_l", note_div_left, c_DIV_A4);
        check_val("b1_div_r", note_div_right, c_DIV_C4);

        // Pause at cycle 5 of beat 2, hold 40 cycles, resume
        tick(20);
        check_val("b2_beat", beat_idx, 2);
        pulse(2);
        check_val("pause_busy", busy, 1);
        tick(1);
        check_val("pause_div_l", note_div_left, 1);
        check_val("pause_div_r", note_div_right, 1);
        tick(38);
        check_val("pause_hold_div_r", note_div_right, 1);
        check_val("pause_hold_beat", beat_idx, 2);
        pulse(2);
        tick(1);
        check_val("resume_div_r", note_div_right, c_DIV_C4);
        tick(9);
        check_val("resume_b2_beat", beat_idx, 2);
        tick(1);
        check_val("resume_b3_beat", beat_idx, 3);
        tick(1);
        check_val("b3_div_l", note_div_left, c_DIV_C4);
        check_val("b3_div_r", note_div_right, 1);

        // Run to end without looping
        tick(974);
        check_val("b63_beat", beat_idx, 63);
        check_val("b63_done", done, 0);
        tick(1);
        check_val("end_done", done, 1);
        check_val("end_beat", beat_idx, 0);
        check_val("end_busy", busy, 0);
        tick(1);
        check_val("end_done_low", done, 0);
        check_val("end_div_l", note_div_left, 1);
        check_val("end_div_r", note_div_right, 1);

        // Looping: done on every wrap, exactly SONG_LEN*16 cycles apart
        loop_en = 1'b1;
        pulse(0);
        wait_done(1100, n_cyc);
        check_val("loop1_len", n_cyc, 1024);
        check_val("loop1_beat", beat_idx, 0);
        check_val("loop1_busy", busy, 1);
        wait_done(1100, n_cyc);
        check_val("loop2_len", n_cyc, 1024);
        tick(1);
        check_val("loop2_done_low", done, 0);
        check_val("loop2_busy", busy, 1);

        // stop+start together in PLAY: stop wins
        pulse(3);
        check_val("ss_busy", busy, 0);
        check_val("ss_beat", beat_idx, 0);
        tick(1);
        check_val("ss_div_l", note_div_left, 1);
        check_val("ss_div_r", note_div_right, 1);
        check_val("ss_done", done, 0);
        loop_en = 1'b0;

        // pause_toggle in IDLE is ignored
        pulse(2);
        check_val("idle_pause_busy", busy, 0);

        // start mid-song restarts from beat 0 with a fresh counter
        pulse(0);
        tick(40);
        check_val("mid_beat", beat_idx, 2);
        pulse(0);
        check_val("restart_beat", beat_idx, 0);
        check_val("restart_busy", busy, 1);
        tick(15);
        check_val("restart_b0_end", beat_idx, 0);
        tick(1);
        check_val("restart_b1", beat_idx, 1);

        // stop while paused
        pulse(2);
        pulse(1);
        check_val("stop_pause_busy", busy, 0);
        check_val("stop_pause_beat", beat_idx, 0);

        // Asynchronous reset mid-song
        pulse(0);
        tick(20);
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_busy", busy, 0);
        check_val("arst_beat", beat_idx, 0);
        check_val("arst_div_l", note_div_left, 1);
        tick(1);
        rst = 1'b0;
        tick(2);
        check_val("arst_no_resume", busy, 0);

`ifdef MELODY_ARTIC_EN
        // Entry 1 repeats code 22 on the left: silence in the last 4 cycles of beat 0
        pulse(0);
        tick(12);
        check_val("artic_pre_l", note_div_left, c_DIV_A4);
        tick(1);
        check_val("artic_gap_l0", note_div_left, 1);
        tick(3);
        check_val("artic_gap_l3", note_div_left, 1);
        check_val("artic_gap_r", note_div_right, 1);
        tick(1);
        check_val("artic_post_l", note_div_left, c_DIV_A4);
        check_val("artic_post_r", note_div_right, c_DIV_C4);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_melody_player
`default_nettype wire
